// File: rtl/memory_requester_pkg.sv
// Shared types and constants for the PDP-8 memory requester.
// Contents:
//   word_t           12-bit PDP-8 word
//   mem_op_t         op codes presented by the core
//   req_state_t      requester FSM states
//   INSTRUCTION_FETCH / DATA_READ   read_type encodings seen by memory_controller
//   AUTO_INDEX_LO/HI                auto-index pointer window (0o010..0o017)
//   is_auto_index()                 window test on a word address
package memory_requester_pkg;

    typedef logic [11:0] word_t;

    typedef enum logic [1:0] {
        OP_FETCH    = 2'd0,
        OP_READ     = 2'd1,
        OP_WRITE    = 2'd2,
        OP_INDIRECT = 2'd3
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT     = 3'd2,
        AI_ISSUE = 3'd3,
        AI_WAIT  = 3'd4,
        RESP     = 3'd5
    } req_state_t;

    localparam logic INSTRUCTION_FETCH = 1'b1;
    localparam logic DATA_READ         = 1'b0;

    localparam word_t AUTO_INDEX_LO = 12'o010;
    localparam word_t AUTO_INDEX_HI = 12'o017;

    function automatic logic is_auto_index(input word_t a);
        return (a >= AUTO_INDEX_LO) && (a <= AUTO_INDEX_HI);
    endfunction

endpackage

// File: rtl/memory_requester_timeout_counter.sv
// Cycle counter used to bound the wait for mem_finished.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   clear    in  zero the count (asserted while a request pulse is issued)
//   enable   in  count one more waited cycle
//   expired  out count has reached TIMEOUT_CYCLES; holds until cleared
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/memory_requester.sv
// CPU-side initiator on the main bus. Takes one memory op at a time from the
// core, issues a single-cycle read/write enable pulse, waits for mem_finished
// and returns the result. Auto-index indirection (pointer at 0o010..0o017)
// reads the pointer, pre-increments it and writes it back before responding.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   address, write_data      bus address / write word (registered, held per op)
//   read_enable, write_enable single-cycle bus request pulses
//   read_data, mem_finished  bus response from memory_controller
//   read_type                INSTRUCTION_FETCH for fetches, DATA_READ otherwise
//   req_valid/ready/op/addr/wdata   request handshake from the core
//   resp_valid/data/err      one-cycle completion pulse; data/err hold afterwards
module memory_requester
    import memory_requester_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] address,
    output logic [11:0] write_data,
    output logic        read_enable,
    output logic        write_enable,
    input  logic [11:0] read_data,
    input  logic        mem_finished,
    output logic        read_type,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [11:0] req_wdata,
    output logic        resp_valid,
    output logic [11:0] resp_data,
    output logic        resp_err
);

    req_state_t state, state_nxt;
    mem_op_t    op;
    logic       tmo_clear, tmo_en, tmo_expired;
    logic       auto_idx;

    // address holds the op address for the whole op, so it doubles as the
    // pointer location for the auto-index write-back.
    assign auto_idx = is_auto_index(address);

    mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        tmo_clear    = 1'b0;
        tmo_en       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                // The responder triggers on every enabled cycle, so the
                // enable is only ever up for this one cycle.
                read_enable  = (op != OP_WRITE);
                write_enable = (op == OP_WRITE);
                tmo_clear    = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (mem_finished) begin
                    state_nxt = (op == OP_INDIRECT && auto_idx) ? AI_ISSUE : RESP;
                end else if (tmo_expired) begin
                    state_nxt = RESP;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            AI_ISSUE: begin
                write_enable = 1'b1;
                tmo_clear    = 1'b1;
                state_nxt    = AI_WAIT;
            end
            AI_WAIT: begin
                if (mem_finished || tmo_expired) begin
                    state_nxt = RESP;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op         <= OP_READ;
            address    <= '0;
            write_data <= '0;
            read_type  <= DATA_READ;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op        <= mem_op_t'(req_op);
                        address   <= req_addr;
                        read_type <= (req_op == OP_FETCH) ? INSTRUCTION_FETCH : DATA_READ;
                        if (req_op == OP_WRITE) write_data <= req_wdata;
                    end
                end
                WAIT: begin
                    if (mem_finished) begin
                        resp_err <= 1'b0;
                        case (op)
                            OP_WRITE: resp_data <= write_data;
                            OP_INDIRECT: begin
                                // Pre-incremented pointer goes out as the
                                // write-back data; 12-bit add wraps 0o7777->0.
                                if (auto_idx) write_data <= read_data + 12'd1;
                                else          resp_data  <= read_data;
                            end
                            default: resp_data <= read_data;
                        endcase
                    end else if (tmo_expired) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                AI_WAIT: begin
                    if (mem_finished) begin
                        resp_data <= write_data;
                        resp_err  <= 1'b0;
                    end else if (tmo_expired) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_requester.sv
// Bench for memory_requester: a behavioural memory responder (mem_finished two
// cycles after an enable pulse), a request driver that pushes expected
// responses into a scoreboard, and a monitor that pops and compares on every
// resp_valid.
module tb_memory_requester;
    import memory_requester_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] address, write_data, read_data, req_addr, req_wdata, resp_data;
    logic        read_enable, write_enable, mem_finished, read_type;
    logic        req_valid, req_ready, resp_valid, resp_err;
    logic [1:0]  req_op;

    always #5 clk = ~clk;

    memory_requester #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .address(address), .write_data(write_data),
        .read_enable(read_enable), .write_enable(write_enable),
        .read_data(read_data), .mem_finished(mem_finished),
        .read_type(read_type),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    // ---------------- memory responder ----------------
    logic [11:0] mem [0:4095];
    logic        resp_on = 1'b1;
    logic        st1 = 1'b0, st2 = 1'b0;
    logic [11:0] rd_q = '0;

    assign mem_finished = st2;
    assign read_data    = rd_q;

    always @(posedge clk) begin
        if (rst) begin
            st1 <= 1'b0;
            st2 <= 1'b0;
        end else begin
            st1 <= resp_on && (read_enable || write_enable);
            st2 <= st1;
            if (resp_on && write_enable) mem[address] = write_data;
            if (resp_on && read_enable)  rd_q <= mem[address];
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        string       name;
        logic [11:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0;
    int   cyc = 0, acc_cyc = 0, resp_cnt = 0;
    int   re_cnt = 0, we_cnt = 0;
    logic last_rt = 1'b0;
    logic both_seen = 1'b0;

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0o%0o, expected 0o%0o", name, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst && req_valid && req_ready) acc_cyc = cyc;
        if (read_enable) begin
            re_cnt++;
            last_rt = read_type;
        end
        if (write_enable) we_cnt++;
        if (read_enable && write_enable) both_seen = 1'b1;
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got resp_valid data 0o%0o, expected none", resp_data);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_data"}, int'(resp_data), int'(e.data));
                chk({e.name, "_err"},  int'(resp_err),  int'(e.err));
                chk({e.name, "_lat"},  cyc - acc_cyc,   e.lat);
            end
            resp_cnt++;
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input string name, input logic [1:0] op, input logic [11:0] a,
                         input logic [11:0] wd, input logic [11:0] ed, input logic ee,
                         input int lat);
        exp_t e;
        int   start;
        e.name = name; e.data = ed; e.err = ee; e.lat = lat;
        sb.push_back(e);
        start = resp_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        // Garbage on the request lines while busy must be ignored.
        req_valid = 1'b0; req_addr = 12'o7777; req_wdata = 12'o7777;
        for (int i = 0; i < 60 && resp_cnt == start; i++) @(posedge clk);
        #1;
        if (resp_cnt == start) begin
            tests++;
            fails++;
            $display("FAIL %s_noresp: got no resp_valid within 60 cycles, expected one", name);
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, start;
        req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready",  int'(req_ready),    1);
        chk("rst_resp_valid", int'(resp_valid),   0);
        chk("rst_re",         int'(read_enable),  0);
        chk("rst_we",         int'(write_enable), 0);
        chk("rst_address",    int'(address),      0);
        chk("rst_wdata",      int'(write_data),   0);
        chk("rst_read_type",  int'(read_type),    int'(DATA_READ));
        chk("rst_resp_data",  int'(resp_data),    0);
        chk("rst_resp_err",   int'(resp_err),     0);
        rst = 1'b0;

        r0 = re_cnt; w0 = we_cnt;
        do_op("write_200", OP_WRITE, 12'o200, 12'o1234, 12'o1234, 1'b0, 4);
        chk("write_we_pulses", we_cnt - w0, 1);
        chk("write_re_pulses", re_cnt - r0, 0);
        chk("write_mem_200",   int'(mem[12'o200]), int'(12'o1234));

        r0 = re_cnt; w0 = we_cnt;
        do_op("read_200", OP_READ, 12'o200, 12'o0, 12'o1234, 1'b0, 4);
        chk("read_re_pulses", re_cnt - r0, 1);
        chk("read_we_pulses", we_cnt - w0, 0);
        chk("read_type_data", int'(last_rt), int'(DATA_READ));

        do_op("fetch_200", OP_FETCH, 12'o200, 12'o0, 12'o1234, 1'b0, 4);
        chk("fetch_read_type", int'(last_rt), int'(INSTRUCTION_FETCH));

        mem[12'o012] = 12'o0377;
        r0 = re_cnt; w0 = we_cnt;
        do_op("ai_012", OP_INDIRECT, 12'o012, 12'o0, 12'o0400, 1'b0, 7);
        chk("ai_012_mem",       int'(mem[12'o012]), int'(12'o0400));
        chk("ai_012_re_pulses", re_cnt - r0, 1);
        chk("ai_012_we_pulses", we_cnt - w0, 1);

        mem[12'o015] = 12'o7777;
        do_op("ai_015_wrap", OP_INDIRECT, 12'o015, 12'o0, 12'o0000, 1'b0, 7);
        chk("ai_015_mem", int'(mem[12'o015]), 0);

        mem[12'o020] = 12'o0055;
        do_op("ind_020", OP_INDIRECT, 12'o020, 12'o0, 12'o0055, 1'b0, 4);
        chk("ind_020_mem", int'(mem[12'o020]), int'(12'o0055));

        mem[12'o010] = 12'o0001;
        do_op("ai_010_lo", OP_INDIRECT, 12'o010, 12'o0, 12'o0002, 1'b0, 7);
        mem[12'o017] = 12'o0100;
        do_op("ai_017_hi", OP_INDIRECT, 12'o017, 12'o0, 12'o0101, 1'b0, 7);
        mem[12'o007] = 12'o0005;
        do_op("ind_007", OP_INDIRECT, 12'o007, 12'o0, 12'o0005, 1'b0, 4);
        chk("ind_007_mem", int'(mem[12'o007]), int'(12'o0005));

        repeat (3) @(posedge clk);
        #1;
        chk("hold_resp_data",  int'(resp_data),  int'(12'o0005));
        chk("hold_resp_valid", int'(resp_valid), 0);

        resp_on = 1'b0;
        do_op("timeout", OP_READ, 12'o300, 12'o0, 12'o0000, 1'b1, 19);
        resp_on = 1'b1;

        // Reset while waiting on memory: op is dropped without a response.
        start = resp_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = OP_READ; req_addr = 12'o200;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_req_ready",  int'(req_ready),  1);
        chk("midrst_resp_valid", int'(resp_valid), 0);
        chk("midrst_address",    int'(address),    0);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_resp", resp_cnt - start, 0);
        do_op("read_after_rst", OP_READ, 12'o200, 12'o0, 12'o1234, 1'b0, 4);

        chk("never_both_enables", int'(both_seen), 0);
        chk("scoreboard_empty",   sb.size(),       0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
